// File: rtl/coinc_bcd_counter.sv
// Two-channel edge counter with a coincidence counter and a retriggerable window.
// All three counts are 4-digit packed BCD that saturate at 9999 with sticky overflow flags.
module coinc_bcd_counter #(
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW_CYCLES = 10,
    parameter int WIN_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse_a,
    input  logic        pulse_b,
    input  logic        count_en,
    input  logic        clear,
    output logic [15:0] digits_A,
    output logic [15:0] digits_B,
    output logic [15:0] digits_C,
    output logic [2:0]  overflow
);

    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES);

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   hist_a, hist_b;
    logic                   edge_a, edge_b;
    logic [WIN_W-1:0]       win_a, win_b;
    logic                   coinc;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Edge events are registered so the pin-to-edge delay is SYNC_STAGES+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
            edge_a <= 1'b0;
            edge_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], pulse_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], pulse_b};
            hist_a <= sync_a[SYNC_STAGES-1];
            hist_b <= sync_b[SYNC_STAGES-1];
            edge_a <= sync_a[SYNC_STAGES-1] & ~hist_a;
            edge_b <= sync_b[SYNC_STAGES-1] & ~hist_b;
        end
    end

    always_comb begin
        coinc = count_en & ((edge_a & edge_b) |
                            (edge_b & (win_a != '0)) |
                            (edge_a & (win_b != '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_A <= '0;
            digits_B <= '0;
            digits_C <= '0;
            overflow <= '0;
            win_a    <= '0;
            win_b    <= '0;
        end else if (clear) begin
            digits_A <= '0;
            digits_B <= '0;
            digits_C <= '0;
            overflow <= '0;
            win_a    <= '0;
            win_b    <= '0;
        end else if (!count_en) begin
            win_a <= '0;
            win_b <= '0;
        end else begin
            if (edge_a) begin
                if (digits_A == 16'h9999) overflow[0] <= 1'b1;
                else                      digits_A    <= bcd_inc(digits_A);
            end
            if (edge_b) begin
                if (digits_B == 16'h9999) overflow[1] <= 1'b1;
                else                      digits_B    <= bcd_inc(digits_B);
            end
            if (coinc) begin
                if (digits_C == 16'h9999) overflow[2] <= 1'b1;
                else                      digits_C    <= bcd_inc(digits_C);
            end
            // A matched pairing disarms both windows so one edge never pairs twice.
            if (coinc) begin
                win_a <= '0;
                win_b <= '0;
            end else begin
                if (edge_a)              win_a <= WIN_LOAD;
                else if (win_a != '0)    win_a <= win_a - WIN_W'(1);
                if (edge_b)              win_b <= WIN_LOAD;
                else if (win_b != '0)    win_b <= win_b - WIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_coinc_bcd_counter.sv
// Directed bench for coinc_bcd_counter: reset, latency, BCD carry, window edges,
// single pairing, saturation/clear and enable gating, with hand-computed expectations.
module tb_coinc_bcd_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pulse_a = 1'b0;
    logic        pulse_b = 1'b0;
    logic        count_en = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] digits_A, digits_B, digits_C;
    logic [2:0]  overflow;

    int checks = 0;
    int passes = 0;

    coinc_bcd_counter #(
        .SYNC_STAGES  (2),
        .WINDOW_CYCLES(10),
        .WIN_W        (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_a (pulse_a),
        .pulse_b (pulse_b),
        .count_en(count_en),
        .clear   (clear),
        .digits_A(digits_A),
        .digits_B(digits_B),
        .digits_C(digits_C),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_a_n(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_a = 1'b1; tick(); tick();
            pulse_a = 1'b0; tick(); tick();
        end
        repeat (4) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; tick();
        clear = 1'b0; tick();
    endtask

    // Pin rises at loop offsets (negative = unused), each held 2 cycles; count_en=1 from en_from.
    task automatic drive(input int a0, input int a1, input int b0, input int b1, input int en_from);
        for (int c = 0; c < 20; c++) begin
            pulse_a  = (a0 >= 0 && c >= a0 && c < a0 + 2) || (a1 >= 0 && c >= a1 && c < a1 + 2);
            pulse_b  = (b0 >= 0 && c >= b0 && c < b0 + 2) || (b1 >= 0 && c >= b1 && c < b1 + 2);
            count_en = (c >= en_from);
            tick();
        end
        pulse_a  = 1'b0;
        pulse_b  = 1'b0;
        count_en = 1'b1;
        repeat (14) tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset_A", digits_A, 16'h0000);
        chk("reset_ovf", {13'd0, overflow}, 16'h0000);
        #20 rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-count
        pulse_a_n(42);
        chk("pre_reset_A", digits_A, 16'h0042);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_A", digits_A, 16'h0000);
        chk("async_reset_B", digits_B, 16'h0000);
        #1 rst_n = 1'b1;
        tick();

        // Pin-to-digit latency
        pulse_a = 1'b1; tick(); tick();
        pulse_a = 1'b0; tick();
        chk("latency_3cyc", digits_A, 16'h0000);
        tick();
        chk("latency_4cyc", digits_A, 16'h0001);
        repeat (4) tick();

        // BCD carry
        do_clear();
        pulse_a_n(1099);
        chk("carry_A_1099", digits_A, 16'h1099);
        chk("carry_B_idle", digits_B, 16'h0000);
        chk("carry_C_idle", digits_C, 16'h0000);
        pulse_a_n(1);
        chk("carry_A_1100", digits_A, 16'h1100);

        // Window boundary
        do_clear();
        drive(0, -1, 10, -1, 0);
        chk("win_10_C", digits_C, 16'h0001);
        drive(0, -1, 11, -1, 0);
        chk("win_11_C", digits_C, 16'h0001);
        drive(0, -1, 0, -1, 0);
        chk("win_same_C", digits_C, 16'h0002);
        chk("win_same_A", digits_A, 16'h0003);
        chk("win_same_B", digits_B, 16'h0003);

        // Single pairing
        do_clear();
        drive(0, -1, 3, 6, 0);
        chk("pair_C", digits_C, 16'h0001);
        chk("pair_B", digits_B, 16'h0002);
        drive(5, -1, 0, -1, 0);
        chk("b_first_C", digits_C, 16'h0002);
        chk("b_first_A", digits_A, 16'h0002);

        // Saturation, then clear colliding with an A edge
        do_clear();
        pulse_a_n(9999);
        chk("sat_A_9999", digits_A, 16'h9999);
        pulse_a_n(3);
        chk("sat_A_hold", digits_A, 16'h9999);
        chk("sat_ovf", {13'd0, overflow}, 16'h0001);
        pulse_a = 1'b1; tick(); tick();
        pulse_a = 1'b0; tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        repeat (4) tick();
        chk("clear_A", digits_A, 16'h0000);
        chk("clear_ovf", {13'd0, overflow}, 16'h0000);

        // Enable gating: A edge while disabled, B edge after re-enable
        drive(0, -1, 2, -1, 4);
        chk("gate_C", digits_C, 16'h0000);
        chk("gate_A", digits_A, 16'h0000);
        chk("gate_B", digits_B, 16'h0001);

        // Raising count_en while pulse_a is held high
        count_en = 1'b0;
        pulse_a  = 1'b1;
        repeat (8) tick();
        count_en = 1'b1;
        repeat (8) tick();
        chk("held_A", digits_A, 16'h0000);
        pulse_a = 1'b0;
        repeat (6) tick();
        chk("held_release_A", digits_A, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
